// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch stage: issues sequential reads (pc+4) to the
// instruction port and buffers {pc, inst} pairs in a DEPTH-entry queue for decode.
module if_prefetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall2,
  input  logic                  br,
  input  logic [ADDR_WIDTH-1:0] br_addr,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_ready,
  input  logic [INST_WIDTH-1:0] ram_data,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  stall_if
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_nx;
  logic [ADDR_WIDTH-1:0]   req_addr, req_addr_nx;
  logic [CW-1:0]           count;
  logic [CW:0]             count_after;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic                    push, pop;

  logic [ADDR_WIDTH-1:0]   pc_q   [DEPTH];
  logic [INST_WIDTH-1:0]   inst_q [DEPTH];

  // Decode-facing side: a redirect hides the head in the same cycle it flushes.
  assign valid_o  = (count != '0) && !br;
  assign pop      = valid_o && !stall2;
  assign stall_if = !valid_o;
  assign pc_o     = (count != '0) ? pc_q[rd_ptr]   : '0;
  assign inst_o   = (count != '0) ? inst_q[rd_ptr] : '0;

  assign ram_read = (state != IDLE);
  assign ram_addr = ram_read ? req_addr : '0;

  // Occupancy after this edge if the returning word is pushed.
  assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (br) begin
          fetch_pc_nx = br_addr;
        end else if (count < CW'(DEPTH)) begin
          state_nx    = FETCH;
          req_addr_nx = fetch_pc;
        end
      end
      FETCH: begin
        if (ram_ready && !br) begin
          push        = 1'b1;
          fetch_pc_nx = req_addr + ADDR_WIDTH'(4);
          if (count_after < (CW+1)'(DEPTH)) begin
            req_addr_nx = req_addr + ADDR_WIDTH'(4);
          end else begin
            state_nx = IDLE;
          end
        end else if (ram_ready && br) begin
          fetch_pc_nx = br_addr;
          state_nx    = IDLE;
        end else if (br) begin
          // The read cannot be cancelled; hold it and discard its data in DROP.
          fetch_pc_nx = br_addr;
          state_nx    = DROP;
        end
      end
      DROP: begin
        if (br)        fetch_pc_nx = br_addr;
        if (ram_ready) state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
      if (br) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // NOTE: queue storage has no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= req_addr;
      inst_q[wr_ptr] <= ram_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, full-queue stall, redirects while a
// read is waiting or completing, repeated redirects in DROP and reset mid-read.
module tb_if_prefetch;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall2 = 1'b0;
  logic          br = 1'b0;
  logic [AW-1:0] br_addr = '0;
  logic          ram_read;
  logic [AW-1:0] ram_addr;
  logic          ram_ready;
  logic [IW-1:0] ram_data;
  logic          valid_o;
  logic [AW-1:0] pc_o;
  logic [IW-1:0] inst_o;
  logic          stall_if;

  int checks = 0;
  int errors = 0;

  // Memory model: answers after mem_lat cycles of ram_read; inst = addr ^ 0xDEAD0000.
  int   mem_lat = 1;
  int   mem_cnt = 0;
  logic mem_ready;
  logic stray_ready = 1'b0;
  logic saw_200 = 1'b0;

  always #5 clk = ~clk;

  if_prefetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall2   (stall2),
    .br       (br),
    .br_addr  (br_addr),
    .ram_read (ram_read),
    .ram_addr (ram_addr),
    .ram_ready(ram_ready),
    .ram_data (ram_data),
    .valid_o  (valid_o),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .stall_if (stall_if)
  );

  assign mem_ready = ram_read && (mem_cnt == mem_lat - 1);
  assign ram_ready = mem_ready || stray_ready;
  assign ram_data  = stray_ready ? 32'hBAD0_BAD0 : (ram_addr ^ 32'hDEAD_0000);

  always @(posedge clk) begin
    if (reset || !ram_read || mem_ready) mem_cnt <= 0;
    else                                 mem_cnt <= mem_cnt + 1;
    if (ram_read && ram_addr == 32'h200) saw_200 <= 1'b1;
  end

  // A push must never land in a full queue.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(dut.push && dut.count == 3'(DEPTH))) else begin
        errors++;
        $error("FAIL overflow: push observed with count=%0d", dut.count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Leaves reset released 2 time units after edge E0; the next step() returns after E1.
  task automatic do_reset(input logic stall_val, input int lat);
    reset   = 1'b1;
    br      = 1'b0;
    stall2  = stall_val;
    mem_lat = lat;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- reset values + streaming with a 1-cycle memory
    do_reset(1'b0, 1);
    check("rst_ram_read", 32'(ram_read), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_valid",    32'(valid_o), 32'd0);
    check("rst_stall_if", 32'(stall_if), 32'd1);
    check("rst_pc",       pc_o, 32'd0);
    check("rst_inst",     inst_o, 32'd0);
    step(); // E1: first request
    check("s1_valid",     32'(valid_o), 32'd0);
    check("s1_ram_read",  32'(ram_read), 32'd1);
    check("s1_ram_addr",  ram_addr, 32'd0);
    step(); // E2: first entry visible
    check("s2_valid",     32'(valid_o), 32'd1);
    check("s2_stall_if",  32'(stall_if), 32'd0);
    check("s2_pc",        pc_o, 32'd0);
    check("s2_inst",      inst_o, 32'hDEAD_0000);
    check("s2_ram_addr",  ram_addr, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("stream_pc", pc_o, 32'(4 * i));
      check("stream_ram_addr", ram_addr, 32'(4 * i + 4));
    end

    // ---------------- downstream stall fills the queue
    do_reset(1'b1, 1);
    repeat (10) step();
    check("full_ram_read", 32'(ram_read), 32'd0);
    check("full_count",    32'(dut.count), 32'd4);
    check("full_valid",    32'(valid_o), 32'd1);
    check("full_pc",       pc_o, 32'd0);
    stall2 = 1'b0;
    settle();
    check("drain_pc0", pc_o, 32'd0);
    step();
    check("drain_pc4", pc_o, 32'd4);
    check("drain_idle", 32'(ram_read), 32'd0);
    step();
    check("drain_pc8", pc_o, 32'd8);
    check("resume_addr", ram_addr, 32'd16);
    step();
    check("drain_pc12", pc_o, 32'd12);
    step();
    check("resume_pc16", pc_o, 32'd16);
    check("resume_inst", inst_o, 32'hDEAD_0010);

    // ---------------- redirect while FETCH waits on a 3-cycle memory
    do_reset(1'b0, 3);
    step(); // E1
    br = 1'b1;
    br_addr = 32'h100;
    settle();
    check("w_ram_addr_pre", ram_addr, 32'd0);
    step(); // E2: DROP
    br = 1'b0;
    check("w_drop_read", 32'(ram_read), 32'd1);
    check("w_drop_addr", ram_addr, 32'd0);
    step(); // E3: stale data returns this cycle
    check("w_drop_addr2", ram_addr, 32'd0);
    step(); // E4
    check("w_idle_read", 32'(ram_read), 32'd0);
    check("w_idle_valid", 32'(valid_o), 32'd0);
    step(); // E5
    check("w_new_addr", ram_addr, 32'h100);
    step();
    step(); // E7
    check("w_not_yet", 32'(valid_o), 32'd0);
    step(); // E8
    check("w_valid", 32'(valid_o), 32'd1);
    check("w_pc", pc_o, 32'h100);
    check("w_inst", inst_o, 32'hDEAD_0100);

    // ---------------- redirect coinciding with ram_ready, queue non-empty
    do_reset(1'b1, 1);
    step();
    step();
    step(); // E3: two entries queued, third arriving
    check("c_pre_valid", 32'(valid_o), 32'd1);
    br = 1'b1;
    br_addr = 32'h40;
    settle();
    check("c_br_valid", 32'(valid_o), 32'd0);
    check("c_br_stall_if", 32'(stall_if), 32'd1);
    step(); // E4
    br = 1'b0;
    check("c_flush_valid", 32'(valid_o), 32'd0);
    check("c_flush_pc", pc_o, 32'd0);
    check("c_flush_read", 32'(ram_read), 32'd0);
    step(); // E5
    check("c_new_addr", ram_addr, 32'h40);
    step(); // E6
    check("c_valid", 32'(valid_o), 32'd1);
    check("c_pc", pc_o, 32'h40);
    check("c_inst", inst_o, 32'hDEAD_0040);

    // ---------------- two redirects, second while in DROP
    do_reset(1'b0, 3);
    step(); // E1
    br = 1'b1;
    br_addr = 32'h200;
    step(); // E2: DROP
    br_addr = 32'h300;
    step(); // E3
    br = 1'b0;
    check("d_held_addr", ram_addr, 32'd0);
    step(); // E4
    check("d_idle", 32'(ram_read), 32'd0);
    step(); // E5
    check("d_new_addr", ram_addr, 32'h300);
    step();
    step();
    step(); // E8
    check("d_pc", pc_o, 32'h300);
    check("d_never_200", 32'(saw_200), 32'd0);

    // ---------------- reset while a read is outstanding
    do_reset(1'b0, 3);
    step(); // E1
    check("r_read_pre", 32'(ram_read), 32'd1);
    reset = 1'b1;
    step(); // E2
    reset = 1'b0;
    stray_ready = 1'b1;
    settle();
    check("r_read_off", 32'(ram_read), 32'd0);
    check("r_valid_off", 32'(valid_o), 32'd0);
    step(); // E3
    stray_ready = 1'b0;
    check("r_stray_ignored", 32'(valid_o), 32'd0);
    check("r_restart_read", 32'(ram_read), 32'd1);
    check("r_restart_addr", ram_addr, 32'd0);
    step();
    step(); // E5
    check("r_not_yet", 32'(valid_o), 32'd0);
    step(); // E6
    check("r_valid", 32'(valid_o), 32'd1);
    check("r_pc", pc_o, 32'd0);
    check("r_inst", inst_o, 32'hDEAD_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
